// File: rtl/mic1_microsequencer_if.sv
// Bus between the MIC-1 microsequencer, its control store and the datapath.
// master = sequencer side, slave = control store / datapath side.
interface mic1_microsequencer_if;
   logic [8:0]  cs_addr;
   logic [35:0] cs_data;
   logic        alu_n;
   logic        alu_z;
   logic [7:0]  mbr;
   logic        mem_ready;
   logic        f0, f1, ena, enb, inva, inc;
   logic        sll8, sra1;
   logic [8:0]  c_sel;
   logic [3:0]  b_sel;
   logic        mem_write, mem_read, mem_fetch;
   logic        exec;
   logic        halted;

   modport master (
      output cs_addr, f0, f1, ena, enb, inva, inc, sll8, sra1, c_sel, b_sel,
             mem_write, mem_read, mem_fetch, exec, halted,
      input  cs_data, alu_n, alu_z, mbr, mem_ready
   );

   modport slave (
      input  cs_addr, f0, f1, ena, enb, inva, inc, sll8, sra1, c_sel, b_sel,
             mem_write, mem_read, mem_fetch, exec, halted,
      output cs_data, alu_n, alu_z, mbr, mem_ready
   );
endinterface

// File: rtl/mic1_microsequencer.sv
// MIC-1 microsequencer: MPC/MIR registers, FETCH/EXEC/MEMWAIT/NEXT/HALT control,
// next-address formation from NEXT_ADDRESS, JAMN/JAMZ and JMPC.
module mic1_microsequencer #(
   parameter logic [8:0] RESET_ADDR = 9'h000,
   parameter logic [8:0] HALT_ADDR  = 9'h1FF
) (
   input  logic                         clk,
   input  logic                         rst,
   mic1_microsequencer_if.master        bus
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_EXEC,
      S_MEMWAIT,
      S_NEXT,
      S_HALT
   } state_t;

   state_t      state, state_nxt;
   logic [8:0]  mpc;
   logic [35:0] mir;
   logic        n_q, z_q;
   logic [8:0]  nxt_addr;
   logic [23:0] ctl;
   logic        mem_op;

   // Pure OR composition: flags and MBR only ever set bits, never carry.
   function automatic logic [8:0] next_addr(input logic [35:0] mi, input logic n,
                                            input logic z, input logic [7:0] mbr_byte);
      logic [8:0] a;
      a    = mi[35:27];
      a[8] = a[8] | (mi[25] & n) | (mi[24] & z);
      if (mi[26])
         a[7:0] = a[7:0] | mbr_byte;
      return a;
   endfunction

   assign nxt_addr = next_addr(mir, n_q, z_q, bus.mbr);
   assign mem_op   = mir[6] | mir[5] | mir[4];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_FETCH;
         mpc   <= RESET_ADDR;
         mir   <= '0;
         n_q   <= 1'b0;
         z_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            S_FETCH: mir <= bus.cs_data;
            S_EXEC: begin
               n_q <= bus.alu_n;
               z_q <= bus.alu_z;
            end
            S_NEXT:  mpc <= nxt_addr;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      ctl       = '0;
      case (state)
         S_FETCH:   state_nxt = S_EXEC;
         S_EXEC: begin
            ctl       = mir[23:0];
            state_nxt = mem_op ? S_MEMWAIT : S_NEXT;
         end
         S_MEMWAIT: if (bus.mem_ready) state_nxt = S_NEXT;
         S_NEXT:    state_nxt = (nxt_addr == HALT_ADDR) ? S_HALT : S_FETCH;
         S_HALT:    state_nxt = S_HALT;
         default:   state_nxt = S_FETCH;
      endcase
   end

   // MIR[23:0] maps bit-for-bit onto the control outputs, gated to EXEC only.
   assign {bus.sll8, bus.sra1, bus.f0, bus.f1, bus.ena, bus.enb, bus.inva, bus.inc,
           bus.c_sel, bus.mem_write, bus.mem_read, bus.mem_fetch, bus.b_sel} = ctl;

   assign bus.cs_addr = mpc;
   assign bus.exec    = (state == S_EXEC);
   assign bus.halted  = (state == S_HALT);

endmodule

// File: tb/tb_mic1_microsequencer.sv
// Scoreboard bench for mic1_microsequencer: control words queued per issued
// microinstruction and matched against the outputs seen in each EXEC cycle.
module tb_mic1_microsequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mic1_microsequencer_if bus ();

   mic1_microsequencer #(
      .RESET_ADDR(9'h000),
      .HALT_ADDR (9'h1FF)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   logic [35:0] rom [512];
   assign bus.cs_data = rom[bus.cs_addr];

   logic [23:0] ctl;
   assign ctl = {bus.sll8, bus.sra1, bus.f0, bus.f1, bus.ena, bus.enb, bus.inva, bus.inc,
                 bus.c_sel, bus.mem_write, bus.mem_read, bus.mem_fetch, bus.b_sel};

   logic [23:0] exp_q [$];
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk_eq(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [35:0] mk(input logic [8:0] na, input logic jmpc, input logic jamn,
                                      input logic jamz, input logic [1:0] sh, input logic [5:0] alu,
                                      input logic [8:0] c, input logic [2:0] mem, input logic [3:0] b);
      return {na, jmpc, jamn, jamz, sh, alu, c, mem, b};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Control outputs: the queued word during EXEC, all zero otherwise.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.exec) begin
            if (exp_q.size() == 0) chk_eq("exec_unexpected", 36'(bus.exec), 36'd0);
            else chk_eq("ctl_exec", 36'(ctl), 36'(exp_q.pop_front()));
         end else begin
            chk_eq("ctl_idle", 36'(ctl), 36'd0);
         end
      end
   end

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) step();
      rst = 1'b0;
      chk_eq("rst_addr",   36'(bus.cs_addr), 36'h000);
      chk_eq("rst_exec",   36'(bus.exec),    36'd0);
      chk_eq("rst_halted", 36'(bus.halted),  36'd0);
      chk_eq("rst_ctl",    36'(ctl),         36'd0);
   endtask

   // Called in a FETCH cycle; leaves the bench in the following FETCH/HALT cycle.
   task automatic exec_one(input int mw, input logic n, input logic z, input logic [7:0] m,
                           input logic [8:0] exp_nxt, input logic exp_halt);
      logic [35:0] w;
      logic [8:0]  a0;
      a0 = bus.cs_addr;
      w  = rom[a0];
      chk_eq("fetch_exec", 36'(bus.exec), 36'd0);
      exp_q.push_back(w[23:0]);
      step();
      chk_eq("exec_hi", 36'(bus.exec), 36'd1);
      bus.alu_n     = n;
      bus.alu_z     = z;
      bus.mem_ready = 1'b1;
      bus.mbr       = ~m;
      step();
      bus.alu_n     = ~n;
      bus.alu_z     = ~z;
      bus.mem_ready = 1'b0;
      if (w[6] | w[5] | w[4]) begin
         for (int i = 1; i <= mw; i++) begin
            bus.mem_ready = (i == mw);
            chk_eq("memwait_exec", 36'(bus.exec),    36'd0);
            chk_eq("memwait_addr", 36'(bus.cs_addr), 36'(a0));
            step();
         end
         bus.mem_ready = 1'b0;
      end
      bus.mbr = m;
      chk_eq("next_exec", 36'(bus.exec),    36'd0);
      chk_eq("next_addr", 36'(bus.cs_addr), 36'(a0));
      step();
      bus.mbr = ~m;
      chk_eq("new_addr",   36'(bus.cs_addr), 36'(exp_nxt));
      chk_eq("new_halted", 36'(bus.halted),  36'(exp_halt));
   endtask

   initial begin
      for (int i = 0; i < 512; i++) rom[i] = '0;
      bus.alu_n     = 1'b0;
      bus.alu_z     = 1'b0;
      bus.mbr       = 8'h00;
      bus.mem_ready = 1'b0;

      // Straight line, then JAMZ taken / not taken
      rom[9'h000] = mk(9'h005, 0, 0, 0, 2'b00, 6'b111100, 9'h001, 3'b000, 4'h0);
      rom[9'h005] = mk(9'h010, 0, 0, 1, 2'b10, 6'b011000, 9'h100, 3'b000, 4'h2);
      do_reset(2);
      exec_one(0, 1'b0, 1'b0, 8'h00, 9'h005, 1'b0);
      exec_one(0, 1'b0, 1'b1, 8'h00, 9'h110, 1'b0);
      do_reset(2);
      exec_one(0, 1'b0, 1'b0, 8'h00, 9'h005, 1'b0);
      exec_one(0, 1'b1, 1'b0, 8'h00, 9'h010, 1'b0);

      // JAMN taken / not taken
      rom[9'h005] = mk(9'h010, 0, 1, 0, 2'b01, 6'b010100, 9'h0AA, 3'b000, 4'h9);
      do_reset(2);
      exec_one(0, 1'b0, 1'b0, 8'h00, 9'h005, 1'b0);
      exec_one(0, 1'b1, 1'b0, 8'h00, 9'h110, 1'b0);
      do_reset(2);
      exec_one(0, 1'b0, 1'b0, 8'h00, 9'h005, 1'b0);
      exec_one(0, 1'b0, 1'b1, 8'h00, 9'h010, 1'b0);

      // JMPC chain, memory stalls, undefined ALU code, halt
      rom[9'h000] = mk(9'h000, 1, 0, 0, 2'b00, 6'b110101, 9'h1FF, 3'b000, 4'hF);
      rom[9'h05A] = mk(9'h100, 1, 0, 0, 2'b01, 6'b001100, 9'h020, 3'b000, 4'h1);
      rom[9'h15A] = mk(9'h1A5, 1, 0, 0, 2'b00, 6'b111100, 9'h004, 3'b010, 4'h7);
      rom[9'h1AF] = mk(9'h030, 1, 1, 0, 2'b00, 6'b110110, 9'h008, 3'b011, 4'h3);
      rom[9'h13C] = mk(9'h1FF, 0, 0, 0, 2'b11, 6'b101011, 9'h155, 3'b100, 4'hC);
      do_reset(2);
      exec_one(0, 1'b0, 1'b0, 8'h5A, 9'h05A, 1'b0);
      exec_one(0, 1'b0, 1'b0, 8'h5A, 9'h15A, 1'b0);
      exec_one(4, 1'b0, 1'b0, 8'h0F, 9'h1AF, 1'b0);
      exec_one(1, 1'b1, 1'b0, 8'h0C, 9'h13C, 1'b0);
      exec_one(2, 1'b0, 1'b1, 8'hFF, 9'h1FF, 1'b1);
      bus.mem_ready = 1'b1;
      for (int i = 0; i < 22; i++) begin
         chk_eq("halt_hold",   36'(bus.halted),  36'd1);
         chk_eq("halt_addr",   36'(bus.cs_addr), 36'h1FF);
         chk_eq("halt_exec",   36'(bus.exec),    36'd0);
         step();
      end
      bus.mem_ready = 1'b0;

      // Reset out of HALT, then abort in EXEC
      rom[9'h000] = mk(9'h005, 0, 0, 0, 2'b00, 6'b111100, 9'h001, 3'b000, 4'h0);
      do_reset(2);
      step();
      chk_eq("abort_in_exec", 36'(bus.exec), 36'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_eq("abort_addr", 36'(bus.cs_addr), 36'h000);
      chk_eq("abort_exec", 36'(bus.exec),    36'd0);
      chk_eq("abort_ctl",  36'(ctl),         36'd0);
      exec_one(0, 1'b0, 1'b0, 8'h00, 9'h005, 1'b0);

      step();
      chk_eq("sb_drain", 36'(exp_q.size()), 36'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mic1_microsequencer.md
Name: mic1_microsequencer

Overview:
- Microprogram sequencer for the MIC-1 datapath.
- Holds MPC and MIR and addresses an external asynchronous-read control store.
- Decodes each 36-bit microinstruction into ALU control lines (F0, F1, ENA, ENB, INVA, INC), shifter, C-bus, B-bus and memory controls.
- Computes the next address from NEXT_ADDRESS, JAMN/JAMZ (ALU N/Z flags) and JMPC (MBR), and stalls on memory handshakes.

Parameters:
- RESET_ADDR, 9'h000: MPC value loaded on reset.
- HALT_ADDR, 9'h1FF: next address that parks the sequencer in HALT.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- cs_addr  out  9  control-store address; equals MPC.
- cs_data  in  36  microinstruction at cs_addr; valid in the same cycle.
- alu_n  in  1  ALU negative flag.
- alu_z  in  1  ALU zero flag.
- mbr  in  8  MBR byte, used for JMPC.
- mem_ready  in  1  memory transaction complete.
- f0, f1, ena, enb, inva, inc  out  1 each  ALU control lines.
- sll8, sra1  out  1 each  shifter controls.
- c_sel  out  9  C-bus register write enables.
- b_sel  out  4  B-bus source select.
- mem_write, mem_read, mem_fetch  out  1 each  memory request pulses.
- exec  out  1  high in the EXEC cycle; datapath registers commit only when exec=1.
- halted  out  1  sequencer parked in HALT.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high, and overrides all else, including mid-operation.
- Reset values: MPC=RESET_ADDR, MIR=0, n_q=0, z_q=0, state=FETCH. All outputs 0 except cs_addr=RESET_ADDR.
- Microinstruction fields (bit ranges):
  - [35:27] NEXT_ADDRESS
  - [26] JMPC, [25] JAMN, [24] JAMZ
  - [23] SLL8, [22] SRA1
  - [21:16] F0, F1, ENA, ENB, INVA, INC (F0 at bit 21)
  - [15:7] C
  - [6] WRITE, [5] READ, [4] FETCH
  - [3:0] B
- State FETCH: MIR <= cs_data. Go to EXEC.
- State EXEC:
  - All control outputs are driven from MIR and exec=1.
  - At the clock edge, n_q<=alu_n and z_q<=alu_z.
  - If any of WRITE, READ or FETCH is set, go to MEMWAIT. Otherwise go to NEXT.
  - Memory outputs pulse for this single cycle only.
  - mem_ready is ignored while in EXEC.
- State MEMWAIT:
  - All control outputs are 0.
  - Stay until mem_ready=1 is sampled (this may be the first MEMWAIT cycle), then go to NEXT.
  - Simultaneous READ and FETCH wait on a single mem_ready.
- State NEXT: compute the next address and load MPC. All control outputs are 0.
  - nxt = NEXT_ADDRESS.
  - nxt[8] |= (JAMN & n_q) | (JAMZ & z_q).
  - If JMPC: nxt[7:0] |= mbr, sampled in this cycle.
  - MPC <= nxt.
  - If nxt == HALT_ADDR, go to HALT. Otherwise go to FETCH.
- State HALT:
  - halted=1, all control outputs 0, MPC holds.
  - Exit only through rst.
- Outside EXEC: every control output is forced to 0, so the ALU output and register writes are never committed twice.
- Timing: minimum 3 cycles per microinstruction (FETCH, EXEC, NEXT), plus one cycle per MEMWAIT cycle.
- Undefined ALU encodings: passed through unchanged; the sequencer does not validate the ALU field.
- Address wrap: 9-bit OR arithmetic only, no carries. mbr bits OR into a set NEXT_ADDRESS bit with no overflow.

Test Plan:
- Reset: hold rst 2 cycles from an arbitrary state -> cs_addr=0x000, exec=0, halted=0, all controls 0; the first FETCH follows release.
- Straight line: ROM[0] has NEXT=0x005, ALU=111100, C=0x001, no memory op.
  - -> exec=1 only in cycle 2, with {f0..inc}=111100 and c_sel=0x001.
  - -> cs_addr=0x005 at cycle 4; period 3 cycles.
- JAMZ: ROM[5] has NEXT=0x010, JAMZ=1.
  - alu_z=1 during EXEC -> cs_addr=0x110.
  - Rerun with alu_z=0 -> cs_addr=0x010.
  - Repeat with JAMN/alu_n for the same results.
- JMPC: NEXT=0x000, JMPC=1, mbr=0x5A -> cs_addr=0x05A. With NEXT=0x100 -> cs_addr=0x15A.
- Memory stall: READ=1, mem_ready held low 3 MEMWAIT cycles then high.
  - -> mem_read high exactly 1 cycle, in EXEC.
  - -> 4 MEMWAIT cycles, then NEXT, then FETCH; exec asserted once.
- Halt and abort:
  - NEXT=0x1FF -> halted=1 persistent, controls stay 0 for 20+ cycles.
  - rst asserted in an EXEC cycle -> next cycle cs_addr=0x000, all controls 0, n_q=z_q=0.
